zstr_arb: RTL and testbench
===========================

ZSTR_ARB -- requirements
Module: zstr_arb

Interface
REQ-001 SHALL have parameter BW, default 8, meaning bus width of each zstr channel.
REQ-002 SHALL have parameter SN, default 4, meaning number of source (requester) channels, SN>=1.
REQ-003 SHALL have parameter SNL, default $clog2(SN) (min 1), meaning width of grant index.
REQ-004 SHALL have parameter BL, default 16, meaning maximum transfers per grant (burst limit), BL>=1.
REQ-005 SHALL have port z_clk, input, 1, meaning system clock (rising edge).
REQ-006 SHALL have port z_rst, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port s_vld, input, SN, meaning per-source transfer valid.
REQ-008 SHALL have port s_lst, input, SN, meaning per-source last transfer of burst.
REQ-009 SHALL have port s_bus, input, SN*BW, meaning per-source grouped bus; source i occupies bits [i*BW +: BW].
REQ-010 SHALL have port s_ack, output, SN, meaning per-source transfer acknowledge.
REQ-011 SHALL have port m_vld, output, 1, meaning shared channel transfer valid.
REQ-012 SHALL have port m_lst, output, 1, meaning shared channel last transfer of grant.
REQ-013 SHALL have port m_bus, output, BW, meaning shared channel grouped bus.
REQ-014 SHALL have port m_ack, input, 1, meaning shared channel acknowledge from sink.
REQ-015 SHALL have port m_gnt, output, SNL, meaning index of currently granted source.
REQ-016 SHALL have port m_bsy, output, 1, meaning grant held (state GRANT).

Function
REQ-017 SHALL define a transfer on a channel as vld & ack high at a rising z_clk edge; zstr sources hold vld/bus until transfer.
REQ-018 SHALL implement two states: IDLE (no grant) and GRANT (source m_gnt owns shared channel).
REQ-019 In IDLE, SHALL drive m_vld=0, m_lst=0, s_ack=0, m_bsy=0; m_bus SHALL be s_bus of m_gnt (don't-care to sink).
REQ-020 In IDLE with any s_vld high, SHALL at next edge enter GRANT with m_gnt = first index with s_vld high searching ptr, ptr+1, ... wrapping modulo SN.
REQ-021 In IDLE with s_vld all zero, SHALL remain IDLE; m_gnt and ptr unchanged.
REQ-022 Arbitration latency SHALL be exactly one cycle: source s_vld rising in IDLE sees s_ack possible no earlier than the following cycle.
REQ-023 In GRANT, SHALL combinationally drive m_vld=s_vld[m_gnt], m_bus=s_bus[m_gnt], s_ack[m_gnt]=m_ack, all other s_ack bits 0, m_bsy=1.
REQ-024 Burst counter cnt (width $clog2(BL)+1) SHALL be 0 on grant entry and increment on each shared-channel transfer.
REQ-025 m_lst SHALL equal s_lst[m_gnt] OR (cnt==BL-1) while in GRANT.
REQ-026 On a shared transfer with m_lst=1, SHALL at that edge return to IDLE, set ptr=(m_gnt+1) mod SN, clear cnt.
REQ-027 Requests pending during release cycle SHALL NOT be granted in the same edge; re-arbitration occurs from IDLE (one idle cycle between grants).
REQ-028 Granted source dropping s_vld mid-burst SHALL NOT release grant; grant held until an m_lst transfer.
REQ-029 Non-granted sources SHALL never receive s_ack=1 regardless of m_ack.
REQ-030 With SN=1, SHALL behave as a pass-through with one-cycle grant latency and BL-limited bursts.

Reset
REQ-031 While z_rst high, SHALL hold state=IDLE, ptr=0, m_gnt=0, cnt=0; outputs m_vld=0, m_lst=0, m_bsy=0, s_ack=0.
REQ-032 Reset asserted mid-burst SHALL immediately (asynchronously) abort grant; no further s_ack until re-arbitration after release.
REQ-033 After z_rst release, first grant SHALL favor source 0 when multiple s_vld are high.

Verification
REQ-034 Reset then s_vld=4'b1111, all s_lst=1, m_ack=1 -> grants in order 0,1,2,3,0 with one IDLE cycle between each, one transfer each.
REQ-035 Source 2 only, 3-transfer burst bus 0x11,0x22,0x33 with s_lst on third -> m_bus sequence 0x11,0x22,0x33, m_lst on third, then IDLE, ptr=3.
REQ-036 BL=4, source 1 streams 10 transfers, s_lst never set -> release after 4th transfer with m_lst=1, re-grant to source 1 if alone.
REQ-037 m_ack held low 5 cycles with source 0 granted and source 3 requesting -> s_ack=0 all, m_vld=1, m_gnt=0 held, no transfers counted.
REQ-038 z_rst pulsed at cycle 2 of a source-2 burst -> outputs zero during reset, m_gnt=0, next grant to lowest requesting index.

Source files
------------

// File: rtl/zstr_arb.sv
// Round-robin arbiter muxing SN zstr sources onto one shared channel; one cycle from request to grant, bursts end on s_lst or after BL transfers.
// Backpressure passes straight through: m_ack reaches only the granted source, and the grant stays put while m_ack is low.
module zstr_arb #(
    parameter int BW  = 8,
    parameter int SN  = 4,
    parameter int SNL = (SN > 1) ? $clog2(SN) : 1,
    parameter int BL  = 16
) (
    input  logic             z_clk,
    input  logic             z_rst,
    input  logic [SN-1:0]    s_vld,
    input  logic [SN-1:0]    s_lst,
    input  logic [SN*BW-1:0] s_bus,
    output logic [SN-1:0]    s_ack,
    output logic             m_vld,
    output logic             m_lst,
    output logic [BW-1:0]    m_bus,
    input  logic             m_ack,
    output logic [SNL-1:0]   m_gnt,
    output logic             m_bsy
);

    localparam int CW = $clog2(BL) + 1;
    localparam logic [SNL-1:0] LAST_SRC = SNL'(SN - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(BL - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [SNL-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic [SNL-1:0] arb_idx;
    logic           arb_hit;
    logic           in_grant;
    logic           xfer;

    // Rotating priority search starting at ptr.
    always_comb begin
        arb_idx = ptr;
        arb_hit = 1'b0;
        for (int k = 0; k < SN; k++) begin
            automatic int idx = int'(ptr) + k;
            if (idx >= SN) idx = idx - SN;
            if (!arb_hit && s_vld[idx]) begin
                arb_hit = 1'b1;
                arb_idx = SNL'(idx);
            end
        end
    end

    assign in_grant = (state == GRANT);
    assign m_bsy    = in_grant;
    assign m_vld    = in_grant & s_vld[m_gnt];
    assign m_lst    = in_grant & (s_lst[m_gnt] | (cnt == CNT_MAX));
    assign m_bus    = s_bus[m_gnt*BW +: BW];
    assign xfer     = m_vld & m_ack;

    always_comb begin
        s_ack = '0;
        if (in_grant) s_ack[m_gnt] = m_ack;
    end

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            state <= IDLE;
            ptr   <= '0;
            m_gnt <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        state <= GRANT;
                        m_gnt <= arb_idx;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        if (m_lst) begin
                            // Always pass through IDLE so the next grant is re-arbitrated.
                            state <= IDLE;
                            ptr   <= (m_gnt == LAST_SRC) ? '0 : m_gnt + 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zstr_arb.sv
// Bench for zstr_arb: directed scenarios plus random traffic, checked every cycle against a behavioural arbiter model.
module tb_zstr_arb;
    localparam int BW  = 8;
    localparam int SN  = 4;
    localparam int SNL = 2;
    localparam int BL  = 4;

    logic             z_clk = 1'b0;
    logic             z_rst;
    logic [SN-1:0]    s_vld, s_lst, s_ack;
    logic [SN*BW-1:0] s_bus;
    logic             m_vld, m_lst, m_ack, m_bsy;
    logic [BW-1:0]    m_bus;
    logic [SNL-1:0]   m_gnt;

    always #5 z_clk = ~z_clk;

    zstr_arb #(.BW(BW), .SN(SN), .SNL(SNL), .BL(BL)) dut (
        .z_clk(z_clk), .z_rst(z_rst),
        .s_vld(s_vld), .s_lst(s_lst), .s_bus(s_bus), .s_ack(s_ack),
        .m_vld(m_vld), .m_lst(m_lst), .m_bus(m_bus), .m_ack(m_ack),
        .m_gnt(m_gnt), .m_bsy(m_bsy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: who owns the channel, beats done in this burst, where the next search starts.
    bit          mb;
    int          mg, mp, mc;
    int          glog[$];
    logic [7:0]  xbus[$];
    bit          xlst[$];
    logic [SN-1:0] xvec;

    task automatic model_reset();
        mb = 0; mg = 0; mp = 0; mc = 0;
    endtask

    function automatic int gl(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    task automatic cycle();
        logic ev, el;
        logic [SN-1:0] ea;
        logic [BW-1:0] eb;
        bit found;
        #1;
        ev = mb && s_vld[mg];
        el = mb && (s_lst[mg] || mc == BL - 1);
        ea = '0;
        if (mb && m_ack) ea[mg] = 1'b1;
        eb = s_bus[mg*BW +: BW];
        chk("m_bsy", 32'(m_bsy), 32'(mb));
        chk("m_vld", 32'(m_vld), 32'(ev));
        chk("m_lst", 32'(m_lst), 32'(el));
        chk("s_ack", 32'(s_ack), 32'(ea));
        chk("m_gnt", 32'(m_gnt), 32'(mg));
        chk("m_bus", 32'(m_bus), 32'(eb));
        if (ev && m_ack) begin
            xbus.push_back(m_bus);
            xlst.push_back(m_lst);
        end
        @(posedge z_clk);
        xvec = s_vld & ea;
        if (!z_rst) begin
            if (!mb) begin
                found = 0;
                for (int k = 0; k < SN; k++) begin
                    if (!found && s_vld[(mp + k) % SN]) begin
                        found = 1;
                        mb = 1;
                        mg = (mp + k) % SN;
                        mc = 0;
                        glog.push_back(mg);
                    end
                end
            end else if (ev && m_ack) begin
                if (el) begin
                    mb = 0;
                    mp = (mg + 1) % SN;
                    mc = 0;
                end else begin
                    mc++;
                end
            end
        end
        @(negedge z_clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (mb && n < budget) begin cycle(); n++; end
        if (mb) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b [3];
        int n;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        xvec = '0;
        z_rst = 1'b1; s_vld = '0; s_lst = '0; s_bus = '0; m_ack = 1'b0;
        model_reset();
        @(negedge z_clk);
        s_vld = '1; m_ack = 1'b1;
        cycle(); cycle();
        chk("rst_gnt", 32'(m_gnt), 32'd0);
        chk("rst_bsy", 32'(m_bsy), 32'd0);
        s_vld = '0; m_ack = 1'b0;
        z_rst = 1'b0;
        cycle();

        // All sources requesting single-beat bursts: strict rotation with idle gaps.
        s_vld = '1; s_lst = '1; m_ack = 1'b1; s_bus = $urandom;
        glog.delete(); xbus.delete();
        repeat (10) cycle();
        chk("order_n", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("order", 32'(gl(i)), 32'(i % 4));
        chk("order_xf", 32'(xbus.size()), 32'd5);
        s_vld = '0; s_lst = '0;
        cycle();

        // Source 2 alone, three-beat burst.
        glog.delete(); xbus.delete(); xlst.delete();
        for (int i = 0; i < 3; i++) begin
            s_vld = 4'b0100;
            s_bus[16 +: 8] = b[i];
            s_lst = (i == 2) ? 4'b0100 : 4'b0000;
            n = 0;
            do begin cycle(); n++; end while (!xvec[2] && n < 8);
            if (!xvec[2]) chk("b35_timeout", 32'd1, 32'd0);
        end
        s_vld = '0; s_lst = '0;
        cycle();
        chk("b35_n", 32'(xbus.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("b35_bus", 32'(xbus.size() > i ? xbus[i] : 8'h00), 32'(b[i]));
            chk("b35_lst", 32'(xlst.size() > i ? xlst[i] : 1'b0), 32'(i == 2));
        end
        chk("b35_gnt", 32'(gl(0)), 32'd2);
        chk("b35_idle", 32'(m_bsy), 32'd0);
        // Pointer now sits past source 2.
        glog.delete();
        s_vld = '1; s_lst = '1;
        cycle(); cycle();
        s_vld = '0; s_lst = '0;
        chk("ptr3", 32'(gl(0)), 32'd3);
        drain(4);

        // Burst limit: source 1 streams without s_lst.
        glog.delete(); xbus.delete(); xlst.delete();
        s_vld = 4'b0010; s_lst = '0; m_ack = 1'b1; s_bus = $urandom;
        n = 0;
        while (xbus.size() < 10 && n < 60) begin
            cycle();
            if (xvec[1]) s_bus = $urandom;
            n++;
        end
        chk("bl_n", 32'(xbus.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            chk("bl_lst", 32'(xlst.size() > i ? xlst[i] : 1'b0), 32'(i % 4 == 3));
        chk("bl_grants", 32'(glog.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk("bl_gnt", 32'(gl(i)), 32'd1);
        s_lst = 4'b0010;
        drain(10);
        s_vld = '0; s_lst = '0;

        // Stall with m_ack low: grant to 0 held while 3 waits.
        s_vld = 4'b1000; s_lst = 4'b1000;
        cycle(); cycle();
        drain(4);
        glog.delete(); xbus.delete();
        s_vld = 4'b1001; s_lst = 4'b1001; m_ack = 1'b0;
        cycle();
        repeat (5) cycle();
        chk("stall_xf", 32'(xbus.size()), 32'd0);
        chk("stall_gnt", 32'(m_gnt), 32'd0);
        chk("stall_vld", 32'(m_vld), 32'd1);
        m_ack = 1'b1;
        cycle();
        s_vld = 4'b1000;
        cycle(); cycle();
        s_vld = '0; s_lst = '0;
        chk("stall_seq0", 32'(gl(0)), 32'd0);
        chk("stall_seq1", 32'(gl(1)), 32'd3);
        drain(4);

        // Asynchronous reset in the middle of a source-2 burst.
        s_vld = 4'b0100; s_lst = '0; m_ack = 1'b1;
        cycle(); cycle();
        #2 z_rst = 1'b1;
        #1;
        chk("arst_vld", 32'(m_vld), 32'd0);
        chk("arst_bsy", 32'(m_bsy), 32'd0);
        chk("arst_ack", 32'(s_ack), 32'd0);
        chk("arst_lst", 32'(m_lst), 32'd0);
        chk("arst_gnt", 32'(m_gnt), 32'd0);
        model_reset();
        s_vld = 4'b0110;
        cycle(); cycle();
        z_rst = 1'b0;
        glog.delete();
        cycle();
        chk("arst_regrant", 32'(gl(0)), 32'd1);
        s_lst = 4'b0110;
        drain(6);
        s_vld = '0; s_lst = '0;
        cycle();

        // Random traffic obeying the hold-until-transfer rule, with occasional drops and one reset pulse.
        xvec = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < SN; i++) begin
                if (!s_vld[i] || xvec[i]) begin
                    s_vld[i] = ($urandom % 3) != 0;
                    s_bus[i*BW +: BW] = 8'($urandom);
                    s_lst[i] = ($urandom % 3) == 0;
                end else if ($urandom % 20 == 0) begin
                    s_vld[i] = 1'b0;
                end
            end
            m_ack = ($urandom % 4) != 0;
            if (c == 200) begin
                z_rst = 1'b1;
                model_reset();
                cycle(); cycle();
                z_rst = 1'b0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
